// File: rtl/vlc_pkg.sv
// vehicle_light_ctrl shared types: FSM states, car-light codes
// and the timer width helper.
package vlc_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_GREEN  = 3'd1,
    ST_YELLOW = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WALK   = 3'd4,
    ST_FAULT  = 3'd5
  } vlc_state_e;

  // {green, yellow, red}
  localparam logic [2:0] LIGHT_RED    = 3'b001;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b100;

  function automatic int timer_width(
    input int a,
    input int b,
    input int c,
    input int d
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/vlc_timer.sv
// Saturating down-counter: load on state entry, count to zero,
// hold at zero.
module vlc_timer #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VAL;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/vehicle_light_ctrl.sv
// Vehicle signal FSM slaved to the crosswalk lights, with a
// pedestrian request latch and a light-combination interlock.
module vehicle_light_ctrl
  import vlc_pkg::*;
#(
  parameter int MIN_GREEN = 8,
  parameter int YELLOW_T  = 3,
  parameter int ALL_RED   = 2,
  parameter int WAIT_MAX  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  input  logic green_walk,
  input  logic orange_walk,
  input  logic red_hand,
  output logic car_green,
  output logic car_yellow,
  output logic car_red,
  output logic walk_req,
  output logic fault
);

  localparam int TW = timer_width(MIN_GREEN, YELLOW_T,
                                  ALL_RED, WAIT_MAX);

  localparam logic [TW-1:0] T_CLEAR  = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] T_GREEN  = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_WAIT   = TW'(WAIT_MAX - 1);

  vlc_state_e    state;
  vlc_state_e    nxt;
  logic          req_pending;
  logic          tmr_zero;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          ped_walk;
  logic          illegal;
  logic [2:0]    light;

  assign ped_walk = green_walk | orange_walk;

  // Walk/clearing lights while cars may move is as bad as a broken combo
  assign illegal =
    !$onehot({green_walk, orange_walk, red_hand}) ||
    (ped_walk && (state == ST_GREEN || state == ST_YELLOW));

  always_comb begin
    nxt = state;
    if (state == ST_FAULT || illegal) begin
      nxt = ST_FAULT;
    end else begin
      case (state)
        ST_CLEAR:  if (tmr_zero) nxt = ST_GREEN;
        ST_GREEN:  if (tmr_zero && req_pending) nxt = ST_YELLOW;
        ST_YELLOW: if (tmr_zero) nxt = ST_WAIT;
        ST_WAIT: begin
          if (tmr_zero)        nxt = ST_FAULT;
          else if (green_walk) nxt = ST_WALK;
        end
        ST_WALK:   if (red_hand) nxt = ST_CLEAR;
        default:   nxt = ST_FAULT;
      endcase
    end
  end

  assign tmr_load = (nxt != state);

  always_comb begin
    tmr_val = '0;
    light   = LIGHT_RED;
    unique case (1'b1)
      (nxt == ST_CLEAR):  tmr_val = T_CLEAR;
      (nxt == ST_GREEN): begin
        tmr_val = T_GREEN;
        light   = LIGHT_GREEN;
      end
      (nxt == ST_YELLOW): begin
        tmr_val = T_YELLOW;
        light   = LIGHT_YELLOW;
      end
      (nxt == ST_WAIT):   tmr_val = T_WAIT;
      default:            tmr_val = '0;
    endcase
  end

  vlc_timer #(
    .W       (TW),
    .RST_VAL (T_CLEAR)
  ) u_timer (
    .clk      (clk),
    .rst_n    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_CLEAR;
      req_pending <= 1'b0;
      car_green   <= 1'b0;
      car_yellow  <= 1'b0;
      car_red     <= 1'b1;
      walk_req    <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state <= nxt;
      // A press on the WALK entry edge must survive the clear
      if (button) begin
        req_pending <= 1'b1;
      end else if (nxt == ST_WALK && state != ST_WALK) begin
        req_pending <= 1'b0;
      end
      {car_green, car_yellow, car_red} <= light;
      walk_req <= (nxt == ST_WAIT);
      fault    <= (nxt == ST_FAULT);
    end
  end

endmodule

// File: tb/tb_vehicle_light_ctrl.sv
// Bench for vehicle_light_ctrl: directed scenarios plus a random
// crosswalk agent, all checked against a phase/count model.
module tb_vehicle_light_ctrl;

  localparam int MG = 8;
  localparam int YT = 3;
  localparam int AR = 2;
  localparam int WM = 64;

  localparam int P_CLEAR = 0;
  localparam int P_GREEN = 1;
  localparam int P_YEL   = 2;
  localparam int P_WAIT  = 3;
  localparam int P_WALK  = 4;
  localparam int P_FAULT = 5;

  logic clk = 1'b0;
  logic reset;
  logic button;
  logic green_walk;
  logic orange_walk;
  logic red_hand;
  logic car_green;
  logic car_yellow;
  logic car_red;
  logic walk_req;
  logic fault;

  always #5 clk = ~clk;

  vehicle_light_ctrl #(
    .MIN_GREEN (MG),
    .YELLOW_T  (YT),
    .ALL_RED   (AR),
    .WAIT_MAX  (WM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .green_walk  (green_walk),
    .orange_walk (orange_walk),
    .red_hand    (red_hand),
    .car_green   (car_green),
    .car_yellow  (car_yellow),
    .car_red     (car_red),
    .walk_req    (walk_req),
    .fault       (fault)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: current phase, cycles spent in it, request flag
  int ph   = P_CLEAR;
  int cnt  = 0;
  bit pend = 1'b0;

  function automatic logic [4:0] m_out();
    case (ph)
      P_GREEN: return 5'b10000;
      P_YEL:   return 5'b01000;
      P_WAIT:  return 5'b00110;
      P_FAULT: return 5'b00101;
      default: return 5'b00100;
    endcase
  endfunction

  task automatic model_step();
    int nx;
    int lit;
    bit ill;
    lit = int'(green_walk) + int'(orange_walk) + int'(red_hand);
    ill = (lit != 1) ||
          ((green_walk || orange_walk) && (ph == P_GREEN || ph == P_YEL));
    nx = ph;
    if (ph == P_FAULT || ill) nx = P_FAULT;
    else begin
      case (ph)
        P_CLEAR: if (cnt + 1 >= AR) nx = P_GREEN;
        P_GREEN: if (pend && cnt + 1 >= MG) nx = P_YEL;
        P_YEL:   if (cnt + 1 >= YT) nx = P_WAIT;
        P_WAIT: begin
          if (cnt + 1 >= WM) nx = P_FAULT;
          else if (green_walk) nx = P_WALK;
        end
        P_WALK:  if (red_hand) nx = P_CLEAR;
        default: nx = P_FAULT;
      endcase
    end
    pend = button || (pend && !(nx == P_WALK && ph != P_WALK));
    cnt  = (nx == ph) ? cnt + 1 : 0;
    ph   = nx;
  endtask

  always @(posedge clk) begin
    if (!reset) begin
      ph = P_CLEAR;
      cnt = 0;
      pend = 1'b0;
    end else begin
      model_step();
    end
    #1;
    chk("cycle", {car_green, car_yellow, car_red, walk_req, fault},
        m_out());
  end

  // Run lengths of green and walk_req, sampled on negedges
  int g_run = 0, last_g = 0, w_run = 0, last_w = 0;

  always @(negedge clk) begin
    if (car_green) g_run++;
    else begin
      if (g_run != 0) last_g = g_run;
      g_run = 0;
    end
    if (walk_req) w_run++;
    else begin
      if (w_run != 0) last_w = w_run;
      w_run = 0;
    end
  end

  task automatic tk(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic bit sel(input int which);
    case (which)
      0: return car_green;
      1: return car_yellow;
      2: return walk_req;
      default: return fault;
    endcase
  endfunction

  task automatic wait_sig(input int which, input int bound,
                          input string nm);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sel(which)) return;
    end
    chk(nm, 32'd0, 32'd1);
  endtask

  int ag, ag_cnt;
  bit rst_lo;

  initial begin
    reset = 1'b0;
    button = 1'b0;
    green_walk = 1'b0;
    orange_walk = 1'b0;
    red_hand = 1'b1;

    tk(2);
    chk("rst_lights", {car_green, car_yellow, car_red}, 3'b001);
    chk("rst_walk_fault", {walk_req, fault}, 2'b00);
    chk("model_rst", m_out(), 5'b00100);
    reset = 1'b1;
    tk(1);
    chk("clear1", {car_green, car_yellow, car_red}, 3'b001);
    tk(1);
    chk("green_rise", {car_green, car_yellow, car_red}, 3'b100);
    chk("model_green", m_out(), 5'b10000);

    // Press at green cycle 2
    tk(1);
    button = 1'b1;
    tk(1);
    button = 1'b0;
    wait_sig(1, 40, "to_yellow");
    tk(1);
    chk("green_len", last_g, 8);
    wait_sig(2, 10, "to_wait");
    tk(3);
    red_hand = 1'b0;
    green_walk = 1'b1;
    tk(1);
    chk("walk_req_drop", {walk_req, car_red}, 2'b01);
    button = 1'b1;
    tk(1);
    button = 1'b0;
    green_walk = 1'b0;
    orange_walk = 1'b1;
    tk(2);
    orange_walk = 1'b0;
    red_hand = 1'b1;
    tk(1);
    chk("clear_a", {car_green, car_red}, 2'b01);
    tk(1);
    chk("clear_b", {car_green, car_red}, 2'b01);
    tk(1);
    chk("green_after", {car_green, car_red}, 2'b10);

    // Press held over from WALK
    wait_sig(1, 40, "to_yellow2");
    tk(1);
    chk("green_len2", last_g, 8);
    wait_sig(2, 10, "to_wait2");
    tk(1);
    red_hand = 1'b0;
    green_walk = 1'b1;
    tk(2);
    green_walk = 1'b0;
    red_hand = 1'b1;
    wait_sig(0, 10, "to_green3");
    tk(20);
    chk("green_hold", {car_green, car_yellow, walk_req}, 3'b100);

    // Timeout in WAIT
    button = 1'b1;
    tk(1);
    button = 1'b0;
    wait_sig(2, 40, "to_wait3");
    wait_sig(3, 80, "timeout");
    tk(1);
    chk("wait_len", last_w, WM);
    chk("fault_lights", {fault, car_red, car_green}, 3'b110);
    for (int i = 0; i < 10; i++) begin
      button = 1'($urandom);
      {green_walk, orange_walk, red_hand} = 3'($urandom);
      tk(1);
    end
    button = 1'b0;
    {green_walk, orange_walk, red_hand} = 3'b001;
    reset = 1'b0;
    #1;
    chk("rst_clears_fault", {fault, car_red}, 2'b01);
    tk(1);
    reset = 1'b1;
    tk(2);
    chk("green_after_rst", car_green, 1'b1);

    // Illegal combo during GREEN
    tk(1);
    green_walk = 1'b1;
    tk(1);
    chk("interlock", {fault, car_red, car_green}, 3'b110);
    green_walk = 1'b0;
    reset = 1'b0;
    tk(1);
    reset = 1'b1;
    tk(2);
    chk("green_after_rst2", car_green, 1'b1);

    // Asynchronous reset while in YELLOW
    button = 1'b1;
    tk(1);
    button = 1'b0;
    wait_sig(1, 40, "to_yellow3");
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_lights", {car_green, car_yellow, car_red}, 3'b001);
    chk("async_rst_flags", {walk_req, fault}, 2'b00);
    tk(1);
    tk(1);
    reset = 1'b1;
    wait_sig(0, 10, "to_green4");
    tk(15);
    chk("no_stale_req", {car_green, car_yellow}, 2'b10);

    // Random traffic with a reactive crosswalk
    ag = 0;
    ag_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      button = ($urandom_range(0, 19) == 0);
      rst_lo = (fault && $urandom_range(0, 15) == 0) ||
               ($urandom_range(0, 1499) == 0);
      reset = !rst_lo;
      case (ag)
        1: {green_walk, orange_walk, red_hand} = 3'b001;
        2: {green_walk, orange_walk, red_hand} = 3'b100;
        3: {green_walk, orange_walk, red_hand} = 3'b010;
        default: {green_walk, orange_walk, red_hand} = 3'b001;
      endcase
      if ($urandom_range(0, 299) == 0)
        {green_walk, orange_walk, red_hand} = 3'($urandom);
      case (ag)
        0: if (walk_req) begin
          ag = 1;
          ag_cnt = ($urandom_range(0, 9) == 0) ? 70 :
                   int'($urandom_range(0, 5));
        end
        1: begin
          if (ag_cnt == 0) begin
            ag = 2;
            ag_cnt = $urandom_range(1, 4);
          end else ag_cnt--;
        end
        2: begin
          ag_cnt--;
          if (ag_cnt <= 0) begin
            ag = 3;
            ag_cnt = $urandom_range(1, 3);
          end
        end
        default: begin
          ag_cnt--;
          if (ag_cnt <= 0) ag = 0;
        end
      endcase
      if (rst_lo) ag = 0;
      tk(1);
    end
    reset = 1'b1;
    tk(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
